// File: rtl/bus_sram_responder_pkg.sv
// Shared types and helpers for the LSU data-bus SRAM responder:
// access-size and FSM encodings plus lane steering/extraction.
package bus_sram_responder_pkg;

  typedef enum logic [1:0] {
    HB_BYTE = 2'b00,
    HB_HALF = 2'b01,
    HB_WORD = 2'b10,
    HB_RSVD = 2'b11
  } hb_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam int unsigned WAIT_W = 3;

  function automatic logic misaligned(hb_e hb, logic [1:0] lsb);
    case (hb)
      HB_BYTE: misaligned = 1'b0;
      HB_HALF: misaligned = lsb[0];
      HB_WORD: misaligned = (lsb != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(hb_e hb, logic [1:0] lsb);
    case (hb)
      HB_BYTE: byte_en = 4'b0001 << lsb;
      HB_HALF: byte_en = lsb[1] ? 4'b1100 : 4'b0011;
      HB_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Replicate the right-aligned data into every lane it could land in.
  function automatic logic [31:0] steer_wdata(hb_e hb, logic [31:0] d);
    case (hb)
      HB_BYTE: steer_wdata = {4{d[7:0]}};
      HB_HALF: steer_wdata = {2{d[15:0]}};
      default: steer_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] extract_rdata(hb_e hb, logic [1:0] lsb, logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lsb, 3'b000};
    case (hb)
      HB_BYTE: extract_rdata = {24'h0, shifted[7:0]};
      HB_HALF: extract_rdata = {16'h0, shifted[15:0]};
      HB_WORD: extract_rdata = shifted;
      default: extract_rdata = '0;
    endcase
  endfunction

endpackage

// File: rtl/bus_sram_responder_if.sv
// LSU REQ/GNT data-bus bundle; master = initiator (LSU), slave = responder.
interface bus_sram_responder_if;
  logic        i_LSU_REQ;
  logic [31:0] i_LSU_ADDR;
  logic        i_LSU_WE;
  logic [1:0]  i_LSU_HB;
  logic [31:0] i_LSU_WDATA;
  logic [31:0] o_LSU_RDATA;
  logic        o_LSU_GNT;
  logic        o_ERR;

  modport master (
    output i_LSU_REQ, i_LSU_ADDR, i_LSU_WE, i_LSU_HB, i_LSU_WDATA,
    input  o_LSU_RDATA, o_LSU_GNT, o_ERR
  );

  modport slave (
    input  i_LSU_REQ, i_LSU_ADDR, i_LSU_WE, i_LSU_HB, i_LSU_WDATA,
    output o_LSU_RDATA, o_LSU_GNT, o_ERR
  );
endinterface

// File: rtl/bus_sram_responder_sram.sv
// Single-port 32-bit RAM with per-byte write enables and registered read data.
module sram_1rw_be #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_sram_responder.sv
// LSU data-bus target: window decode, wait-state FSM, byte/half/word access
// to an internal SRAM, one-cycle GNT with ERR for misaligned/reserved sizes.
module bus_sram_responder
  import bus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic           i_CLK,
  input logic           i_RST,
  bus_sram_responder_if.slave bus
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WINDOW = 32'(DEPTH_WORDS * 4);

  logic [31:0] offset;
  logic        hit;
  hb_e         hb_in;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [AW+1:0]     off_q, off_d;
  logic              we_q, we_d;
  hb_e               hb_q, hb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        sram_en;
  logic [31:0] sram_rd;
  logic        gnt;
  logic [31:0] resp_rdata;

  assign offset = bus.i_LSU_ADDR - BASE_ADDR;
  assign hit    = offset < WINDOW;
  assign hb_in  = hb_e'(bus.i_LSU_HB);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    we_d    = we_q;
    hb_d    = hb_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_LSU_REQ && hit) begin
          off_d   = offset[AW+1:0];
          we_d    = bus.i_LSU_WE;
          hb_d    = hb_in;
          wdata_d = bus.i_LSU_WDATA;
          err_d   = misaligned(hb_in, offset[1:0]);
          cnt_d   = WAIT_W'(WAIT_STATES);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gating with i_RST makes reset in the commit cycle win over the write.
  assign sram_en = (state_q == S_ACCESS) && (cnt_q == '0) && !err_q && !i_RST;

  sram_1rw_be #(.DEPTH(DEPTH_WORDS)) u_sram (
    .clk_i   (i_CLK),
    .en_i    (sram_en),
    .we_i    (we_q),
    .be_i    (byte_en(hb_q, off_q[1:0])),
    .addr_i  (off_q[AW+1:2]),
    .wdata_i (steer_wdata(hb_q, wdata_q)),
    .rdata_o (sram_rd)
  );

  assign gnt        = (state_q == S_RESP);
  assign resp_rdata = (we_q || err_q) ? '0 : extract_rdata(hb_q, off_q[1:0], sram_rd);
  // Read data is shown live during RESP and then held in rdata_q.
  assign rdata_d    = gnt ? resp_rdata : rdata_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      hb_q    <= HB_BYTE;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      we_q    <= we_d;
      hb_q    <= hb_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.o_LSU_GNT   = gnt;
  assign bus.o_ERR       = gnt && err_q;
  assign bus.o_LSU_RDATA = rdata_d;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed plus randomized checks of bus_sram_responder against a byte-level memory model.
module tb_bus_sram_responder;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  bus_sram_responder_if bus0();
  bus_sram_responder_if bus1();

  bus_sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut0 (
    .i_CLK(clk), .i_RST(rst0), .bus(bus0)
  );
  bus_sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut1 (
    .i_CLK(clk), .i_RST(rst1), .bus(bus1)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] mem0 [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] hb);
    return (hb == 2'd0) ? 1 : (hb == 2'd1) ? 2 : (hb == 2'd2) ? 4 : 0;
  endfunction

  function automatic logic is_err(input int a, input logic [1:0] hb);
    int s;
    s = size_of(hb);
    return (s == 0) || ((a % s) != 0);
  endfunction

  function automatic logic [31:0] model_read(input int a, input logic [1:0] hb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < size_of(hb); i++) r[i*8 +: 8] = mem0[a/4][((a+i)%4)*8 +: 8];
    return r;
  endfunction

  task automatic model_write(input int a, input logic [1:0] hb, input logic [31:0] wd);
    for (int i = 0; i < size_of(hb); i++) mem0[a/4][((a+i)%4)*8 +: 8] = wd[i*8 +: 8];
  endtask

  // One transaction on dut0 (WAIT_STATES=1): GNT expected 3 edges after the request cycle.
  task automatic txn(input logic [31:0] addr, input logic we, input logic [1:0] hb,
                     input logic [31:0] wd, input string tag, output logic [31:0] got);
    int lat;
    int a;
    logic e;
    logic [31:0] exp_rd;
    a = int'(addr);
    e = is_err(a, hb);
    exp_rd = '0;
    if (!e) begin
      if (we) model_write(a, hb, wd);
      else    exp_rd = model_read(a, hb);
    end
    @(negedge clk);
    bus0.i_LSU_REQ = 1'b1; bus0.i_LSU_ADDR = addr; bus0.i_LSU_WE = we;
    bus0.i_LSU_HB = hb; bus0.i_LSU_WDATA = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus0.o_LSU_GNT && lat < 20);
    bus0.i_LSU_REQ = 1'b0;
    got = bus0.o_LSU_RDATA;
    check({tag, ":lat"}, 32'(lat), 32'd3);
    check({tag, ":rdata"}, bus0.o_LSU_RDATA, exp_rd);
    check({tag, ":err"}, {31'b0, bus0.o_ERR}, {31'b0, e});
    @(posedge clk); #1;
    check({tag, ":gnt_one_cycle"}, {31'b0, bus0.o_LSU_GNT}, 32'd0);
    check({tag, ":rdata_hold"}, bus0.o_LSU_RDATA, exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.i_LSU_REQ = 1'b0; bus0.i_LSU_ADDR = '0; bus0.i_LSU_WE = 1'b0;
    bus0.i_LSU_HB = 2'b00; bus0.i_LSU_WDATA = '0;
    bus1.i_LSU_REQ = 1'b0; bus1.i_LSU_ADDR = '0; bus1.i_LSU_WE = 1'b0;
    bus1.i_LSU_HB = 2'b00; bus1.i_LSU_WDATA = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:gnt", {31'b0, bus0.o_LSU_GNT}, 32'd0);
    check("reset:err", {31'b0, bus0.o_ERR}, 32'd0);
    check("reset:rdata", bus0.o_LSU_RDATA, 32'd0);
    check("reset1:gnt", {31'b0, bus1.o_LSU_GNT}, 32'd0);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;

    for (int w = 0; w < 64; w++) txn(32'(w*4), 1'b1, 2'b10, $urandom, "init", rd);

    // Directed vectors
    txn(32'h10, 1'b1, 2'b10, 32'hDEADBEEF, "t1_wr", rd);
    txn(32'h10, 1'b0, 2'b10, 32'h0, "t1_rd", rd);
    check("t1_lit", rd, 32'hDEADBEEF);
    txn(32'h13, 1'b1, 2'b00, 32'h000000AA, "t2_wr", rd);
    txn(32'h10, 1'b0, 2'b10, 32'h0, "t2_rdw", rd);
    check("t2_lit", rd, 32'hAAADBEEF);
    txn(32'h12, 1'b0, 2'b00, 32'h0, "t2_rdb", rd);
    check("t2b_lit", rd, 32'h000000AD);
    txn(32'h12, 1'b0, 2'b01, 32'h0, "t3_rdh", rd);
    check("t3_lit", rd, 32'h0000AAAD);
    txn(32'h10, 1'b1, 2'b01, 32'hFFFF1234, "t3_wrh", rd);
    txn(32'h10, 1'b0, 2'b10, 32'h0, "t3_rdw", rd);
    check("t3w_lit", rd, 32'hAAAD1234);
    txn(32'h11, 1'b0, 2'b01, 32'h0, "t4_mis", rd);
    txn(32'h10, 1'b0, 2'b11, 32'h0, "t4_rsv", rd);
    txn(32'h11, 1'b1, 2'b01, 32'h5555, "t4_miswr", rd);
    txn(32'h12, 1'b1, 2'b10, 32'h77777777, "t4_miswrw", rd);
    txn(32'h10, 1'b0, 2'b10, 32'h0, "t4_unch", rd);
    check("t4_lit", rd, 32'hAAAD1234);

    // Out-of-window request is ignored
    @(negedge clk);
    bus0.i_LSU_REQ = 1'b1; bus0.i_LSU_ADDR = 32'h0000_1000; bus0.i_LSU_WE = 1'b1;
    bus0.i_LSU_HB = 2'b10; bus0.i_LSU_WDATA = 32'h12345678;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      check("t5_miss_gnt", {31'b0, bus0.o_LSU_GNT}, 32'd0);
    end
    bus0.i_LSU_REQ = 1'b0;
    txn(32'h0, 1'b0, 2'b10, 32'h0, "t5_after", rd);

    // Reset during ACCESS with wait count still pending
    @(negedge clk);
    bus0.i_LSU_REQ = 1'b1; bus0.i_LSU_ADDR = 32'h20; bus0.i_LSU_WE = 1'b1;
    bus0.i_LSU_HB = 2'b10; bus0.i_LSU_WDATA = 32'h55;
    @(posedge clk);
    @(negedge clk);
    rst0 = 1'b1; bus0.i_LSU_REQ = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("t6_nognt", {31'b0, bus0.o_LSU_GNT}, 32'd0);
    end
    check("t6_rst_rdata", bus0.o_LSU_RDATA, 32'd0);
    txn(32'h20, 1'b0, 2'b10, 32'h0, "t6_old", rd);

    // Reset in the commit cycle
    @(negedge clk);
    bus0.i_LSU_REQ = 1'b1; bus0.i_LSU_ADDR = 32'h24; bus0.i_LSU_WE = 1'b1;
    bus0.i_LSU_HB = 2'b10; bus0.i_LSU_WDATA = 32'h66;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst0 = 1'b1; bus0.i_LSU_REQ = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("t6c_nognt", {31'b0, bus0.o_LSU_GNT}, 32'd0);
    end
    txn(32'h24, 1'b0, 2'b10, 32'h0, "t6c_old", rd);

    // Randomized traffic in the initialized region
    for (int n = 0; n < 150; n++) begin
      txn(32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          $urandom, "rand", rd);
    end

    // WAIT_STATES=0: back-to-back requests, REQ held across GNT
    @(negedge clk);
    bus1.i_LSU_REQ = 1'b1; bus1.i_LSU_ADDR = 32'h40; bus1.i_LSU_WE = 1'b1;
    bus1.i_LSU_HB = 2'b10; bus1.i_LSU_WDATA = 32'h12345678;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus1.o_LSU_GNT && lat < 20);
    check("t7_first_lat", 32'(lat), 32'd2);
    check("t7_first_err", {31'b0, bus1.o_ERR}, 32'd0);
    bus1.i_LSU_WE = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus1.o_LSU_GNT && lat < 20);
    bus1.i_LSU_REQ = 1'b0;
    check("t7_second_lat", 32'(lat), 32'd5);
    check("t7_rdata", bus1.o_LSU_RDATA, 32'h12345678);
    @(posedge clk); #1;
    check("t7_gnt_one_cycle", {31'b0, bus1.o_LSU_GNT}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
